seq_alu: RTL

Parametrised multi-cycle ALU for the CPU datapath, the successor of the single-cycle combinational ALU. It implements the same 4-bit operation encoding plus unsigned multiply/divide, with a configurable data width. Single-cycle operations complete in one clock; multiply and divide use an iterative shift-add / restoring-subtract engine behind a start/busy/done handshake. The block reports real signed overflow, unsigned overflow and divide-by-zero flags, which the old block tied to 0.

---
 rtl/seq_alu.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops plus an iterative
// shift-add multiplier and restoring divider behind a start/busy/done handshake.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             Start,
    input  logic [3:0]       S,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Result2,
    output logic             Equal,
    output logic             Overflow,
    output logic             UOF,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX,
        DONE
    } state_t;

    state_t             st;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   m_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_q;

    logic               accept;
    logic               sgn_in;
    logic               iter_in;
    logic               dz_in;
    logic [WIDTH-1:0]   xa;
    logic [WIDTH-1:0]   ya;

    always_comb begin
        accept  = Start && (st == IDLE || st == DONE);
        sgn_in  = (S == 4'd3) || (S == 4'd4);
        iter_in = (S == 4'd3) || (S == 4'd4) ||
                  (S == 4'd13) || (S == 4'd14);
        dz_in   = ((S == 4'd4) || (S == 4'd14)) && (Y == '0);
        xa      = (sgn_in && X[M]) ? -X : X;
        ya      = (sgn_in && Y[M]) ? -Y : Y;
    end

    logic               is_mul;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [2*WIDTH-1:0] fix_acc;

    // One engine step: multiply adds into the high half and shifts right,
    // divide shifts left and keeps the subtraction when it does not borrow.
    always_comb begin
        is_mul  = (op_q == 4'd3) || (op_q == 4'd13);
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                  {1'b0, (acc[0] ? m_q : {WIDTH{1'b0}})};
        mul_nxt = {mul_sum, acc[WIDTH-1:1]};
        div_sh  = {acc[2*WIDTH-1:WIDTH], acc[M]};
        div_diff = div_sh - {1'b0, m_q};
        if (div_diff[WIDTH])
            div_nxt = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        q_mag = acc[WIDTH-1:0];
        r_mag = acc[2*WIDTH-1:WIDTH];
        if (is_mul)
            fix_acc = neg_q ? -acc : acc;
        else
            fix_acc = {((op_q == 4'd4) && x_q[M]) ? -r_mag : r_mag,
                       neg_q ? -q_mag : q_mag};
    end

    logic [WIDTH-1:0] res_c;
    logic [WIDTH-1:0] res2_c;
    logic             eq_c;
    logic             ov_c;
    logic             uof_c;
    logic             dz_c;
    logic [WIDTH:0]   add_c;
    logic [WIDTH:0]   sub_c;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] minint;

    always_comb begin
        res_c  = '0;
        res2_c = '0;
        eq_c   = (x_q == y_q);
        ov_c   = 1'b0;
        uof_c  = 1'b0;
        dz_c   = 1'b0;
        add_c  = {1'b0, x_q} + {1'b0, y_q};
        sub_c  = {1'b0, x_q} - {1'b0, y_q};
        sh     = y_q[SHW-1:0];
        minint = {1'b1, {(WIDTH-1){1'b0}}};
        case (op_q)
            4'd0: res_c = x_q << sh;
            4'd1: res_c = $signed(x_q) >>> sh;
            4'd2: res_c = x_q >> sh;
            4'd3, 4'd13: begin
                res_c  = acc[WIDTH-1:0];
                res2_c = acc[2*WIDTH-1:WIDTH];
                uof_c  = |acc[2*WIDTH-1:WIDTH];
            end
            4'd4, 4'd14: begin
                if (y_q == '0) begin
                    res_c  = '1;
                    res2_c = x_q;
                    dz_c   = 1'b1;
                end else begin
                    res_c  = acc[WIDTH-1:0];
                    res2_c = acc[2*WIDTH-1:WIDTH];
                    ov_c   = (op_q == 4'd4) && (x_q == minint) &&
                             (y_q == '1);
                end
            end
            4'd5: begin
                res_c = add_c[WIDTH-1:0];
                uof_c = add_c[WIDTH];
                ov_c  = (x_q[M] == y_q[M]) && (add_c[M] != x_q[M]);
            end
            4'd6: begin
                res_c = sub_c[WIDTH-1:0];
                uof_c = sub_c[WIDTH];
                ov_c  = (x_q[M] != y_q[M]) && (sub_c[M] != x_q[M]);
            end
            4'd7:  res_c = x_q & y_q;
            4'd8:  res_c = x_q | y_q;
            4'd9:  res_c = x_q ^ y_q;
            4'd10: res_c = ~(x_q | y_q);
            4'd11: res_c = {{(WIDTH-1){1'b0}},
                            ($signed(x_q) > $signed(y_q))};
            4'd12: res_c = {{(WIDTH-1){1'b0}}, (x_q > y_q)};
            default: eq_c = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st       <= IDLE;
            op_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            m_q      <= '0;
            acc      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Result   <= '0;
            Result2  <= '0;
            Equal    <= 1'b0;
            Overflow <= 1'b0;
            UOF      <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (st)
                IDLE: ;
                ITER: begin
                    acc <= is_mul ? mul_nxt : div_nxt;
                    if (cnt == '0)
                        st <= FIX;
                    else
                        cnt <= cnt - 1'b1;
                end
                FIX: begin
                    acc  <= fix_acc;
                    Busy <= 1'b0;
                    st   <= DONE;
                end
                DONE: begin
                    Done     <= 1'b1;
                    Result   <= res_c;
                    Result2  <= res2_c;
                    Equal    <= eq_c;
                    Overflow <= ov_c;
                    UOF      <= uof_c;
                    DivZero  <= dz_c;
                    st       <= IDLE;
                end
                default: st <= IDLE;
            endcase
            // Acceptance in DONE overrides the return to IDLE.
            if (accept) begin
                op_q  <= S;
                x_q   <= X;
                y_q   <= Y;
                neg_q <= sgn_in && (X[M] ^ Y[M]);
                if ((S == 4'd3) || (S == 4'd13)) begin
                    m_q <= xa;
                    acc <= {{WIDTH{1'b0}}, ya};
                end else begin
                    m_q <= ya;
                    acc <= {{WIDTH{1'b0}}, xa};
                end
                if (iter_in && !dz_in) begin
                    st   <= ITER;
                    Busy <= 1'b1;
                    cnt  <= CW'(WIDTH - 1);
                end else begin
                    st <= DONE;
                end
            end
        end
    end

endmodule
